// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants and helpers for the register-write arbiter.
//   RR_PTR_RST : round-robin pointer value after reset (requester 0 first)
//   wrap_inc   : index + 1 modulo n, used for the pointer advance
package reg_write_arbiter_pkg;

  localparam int RR_PTR_RST = 0;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Requester / register-bank bus of the write arbiter.
//   req, req_addr, req_data : per-requester write requests (packed, requester i at [i*W +: W])
//   ack                     : one-cycle grant pulse back to the requester
//   reg_en, reg_data        : one-hot enable and common data into the register bank
//   err, busy               : out-of-range write flag, any-request-pending flag
// slave = arbiter side, master = requester/bank side.
interface reg_write_arbiter_if #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*AW-1:0]     req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REGS-1:0]       reg_en;
  logic [DATA_W-1:0]         reg_data;
  logic                      err;
  logic                      busy;

  modport slave (
    input  req, req_addr, req_data,
    output ack, reg_en, reg_data, err, busy
  );

  modport master (
    output req, req_addr, req_data,
    input  ack, reg_en, reg_data, err, busy
  );
endinterface

// File: rtl/reg_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
//   eligible : requests competing this cycle
//   rr_ptr   : highest-priority index this cycle
//   grant    : one-hot winner (all zero if nothing eligible)
//   winner   : binary index of the winner
//   gnt_vld  : a winner exists
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      winner,
  output logic               gnt_vld
);
  int idx;

  // Walk the rotation starting at rr_ptr; first eligible index wins.
  always_comb begin
    grant   = '0;
    winner  = '0;
    gnt_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == idx && eligible[i] && !gnt_vld) begin
          gnt_vld  = 1'b1;
          grant[i] = 1'b1;
          winner   = PW'(i);
        end
      end
    end
  end
endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single write port of a register bank.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : requester side (req/req_addr/req_data -> ack) and bank side
//                (reg_en one-hot, reg_data), plus err and busy
// One write issues per cycle; all outputs are registered, so a request
// seen in cycle N is issued (ack + bank enable) in cycle N+1.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int DATA_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  reg_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  ack_q, ack_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [DATA_W-1:0]   reg_data_q, reg_data_d;
  logic                err_q, err_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  eligible, grant;
  logic [PW-1:0]       winner;
  logic                gnt_vld;
  logic [AW-1:0]       win_addr;
  logic [DATA_W-1:0]   win_data;

  // A requester still holds req during its ack cycle; mask it so the same
  // request is not granted twice.
  assign eligible = bus.req & ~ack_q;
  assign bus.busy = |eligible;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .eligible (eligible),
    .rr_ptr   (rr_ptr_q),
    .grant    (grant),
    .winner   (winner),
    .gnt_vld  (gnt_vld)
  );

  always_comb begin
    ack_d      = grant;
    reg_en_d   = '0;
    reg_data_d = reg_data_q;
    err_d      = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    win_addr   = bus.req_addr[int'(winner)*AW +: AW];
    win_data   = bus.req_data[int'(winner)*DATA_W +: DATA_W];
    if (gnt_vld) begin
      reg_data_d = win_data;
      rr_ptr_d   = PW'(wrap_inc(int'(winner), NUM_REQ));
      // Out-of-range targets are acked but flagged and never enabled.
      if (int'(win_addr) < NUM_REGS) reg_en_d[win_addr] = 1'b1;
      else                           err_d              = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q      <= '0;
      reg_en_q   <= '0;
      reg_data_q <= '0;
      err_q      <= 1'b0;
      rr_ptr_q   <= PW'(RR_PTR_RST);
    end else begin
      ack_q      <= ack_d;
      reg_en_q   <= reg_en_d;
      reg_data_q <= reg_data_d;
      err_q      <= err_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.reg_en   = reg_en_q;
  assign bus.reg_data = reg_data_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter (4 requesters, 6 registers so bad addresses exist).
// A reference model predicts each issue cycle from the rotation order and the
// previous grant; a bank model is fed by the predicted writes.
module tb_reg_write_arbiter;
  localparam int NQ = 4;
  localparam int NR = 6;
  localparam int DW = 32;
  localparam int AW = $clog2(NR);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_write_arbiter_if #(.NUM_REQ(NQ), .NUM_REGS(NR), .DATA_W(DW)) bif();

  reg_write_arbiter #(.NUM_REQ(NQ), .NUM_REGS(NR), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  // Register bank driven by the DUT outputs.
  logic [DW-1:0] dut_bank [NR];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) dut_bank[i] <= '0;
    end else begin
      for (int i = 0; i < NR; i++) if (bif.reg_en[i]) dut_bank[i] <= bif.reg_data;
    end
  end

  // Stimulus and model state
  logic [NQ-1:0] t_req;
  logic [AW-1:0] t_addr [NQ];
  logic [DW-1:0] t_data [NQ];
  logic [NQ-1:0] exp_ack;
  logic [NR-1:0] exp_en;
  logic [DW-1:0] exp_data;
  logic          exp_err;
  logic [DW-1:0] m_bank [NR];
  logic [DW-1:0] snap   [NR];
  int            m_last;
  int            vec = 0;
  int            mis = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] e);
    vec++;
    if (act !== e) begin
      mis++;
      $display("FAIL %s: got %0h want %0h", nm, act, e);
    end
  endtask

  task automatic apply();
    bif.req = t_req;
    for (int i = 0; i < NQ; i++) begin
      bif.req_addr[i*AW +: AW] = t_addr[i];
      bif.req_data[i*DW +: DW] = t_data[i];
    end
  endtask

  // Winner = eligible requester closest after the last one granted.
  function automatic int pick(input logic [NQ-1:0] e);
    int best = -1;
    int bd   = NQ;
    for (int i = 0; i < NQ; i++) begin
      if (e[i]) begin
        int d = (i - m_last - 1 + 2*NQ) % NQ;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic model_reset();
    exp_ack = '0; exp_en = '0; exp_data = '0; exp_err = 1'b0;
    m_last = NQ - 1;
    for (int i = 0; i < NR; i++) m_bank[i] = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    t_req = '0;
    apply();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: predict, step, compare everything.
  task automatic tick();
    int w;
    int a;
    apply();
    w = pick(t_req & ~exp_ack);
    @(posedge clk);
    for (int i = 0; i < NR; i++) if (exp_en[i]) m_bank[i] = exp_data;
    exp_ack = '0; exp_en = '0; exp_err = 1'b0;
    if (w >= 0) begin
      exp_ack[w] = 1'b1;
      a          = int'(t_addr[w]);
      exp_data   = t_data[w];
      if (a < NR) exp_en[a] = 1'b1;
      else        exp_err   = 1'b1;
      m_last = w;
    end
    #1;
    chk("ack",      bif.ack,      exp_ack);
    chk("reg_en",   bif.reg_en,   exp_en);
    chk("reg_data", bif.reg_data, exp_data);
    chk("err",      bif.err,      exp_err);
    chk("busy",     bif.busy,     |(t_req & ~exp_ack));
    for (int i = 0; i < NR; i++) chk("bank", dut_bank[i], m_bank[i]);
  endtask

  initial begin
    for (int i = 0; i < NQ; i++) begin t_addr[i] = '0; t_data[i] = '0; end
    do_reset();

    // Reset state
    chk("rst_ack",  bif.ack,      0);
    chk("rst_en",   bif.reg_en,   0);
    chk("rst_data", bif.reg_data, 0);
    chk("rst_err",  bif.err,      0);

    // 1: reset mid-grant, then lowest pending index wins
    t_req = 4'b0010; t_addr[1] = 3'd1; t_data[1] = 32'h1111_0001;
    tick();
    chk("t1_pre_ack", bif.ack, 4'b0010);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t1_ack0",  bif.ack,      0);
    chk("t1_en0",   bif.reg_en,   0);
    chk("t1_data0", bif.reg_data, 0);
    chk("t1_err0",  bif.err,      0);
    t_req = 4'b1010; t_addr[3] = 3'd0; t_data[3] = 32'h3333_0003;
    apply();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t1_first", bif.ack, 4'b0010);
    t_req = 4'b0000;
    tick(); tick();

    // 2: single request
    t_req = 4'b0100; t_addr[2] = 3'd3; t_data[2] = 32'hDEAD_BEEF;
    tick();
    chk("t2_ack",  bif.ack,      4'b0100);
    chk("t2_en",   bif.reg_en,   6'b001000);
    chk("t2_data", bif.reg_data, 32'hDEAD_BEEF);
    t_req = 4'b0000;
    tick();
    chk("t2_bank", dut_bank[3], 32'hDEAD_BEEF);

    // 3: all four held -> strict rotation, no gaps
    do_reset();
    for (int i = 0; i < NQ; i++) begin t_addr[i] = AW'(i); t_data[i] = 32'h100 + i; end
    t_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [NQ-1:0] e3;
      tick();
      e3 = 4'b0001 << (k % 4);
      chk("t3_rot", bif.ack, e3);
    end

    // 4: after req3, 1001 -> req0 then req3; lone req2 granted at once
    t_req = 4'b1001;
    tick();
    chk("t4_a", bif.ack, 4'b0001);
    t_req = 4'b1000;
    tick();
    chk("t4_b", bif.ack, 4'b1000);
    t_req = 4'b0100;
    tick();
    chk("t4_c", bif.ack, 4'b0100);
    t_req = 4'b0000;
    tick();

    // 5: out-of-range address
    for (int i = 0; i < NR; i++) snap[i] = dut_bank[i];
    t_req = 4'b0001; t_addr[0] = 3'd7; t_data[0] = 32'h5555_5555;
    tick();
    chk("t5_ack", bif.ack,    4'b0001);
    chk("t5_err", bif.err,    1);
    chk("t5_en",  bif.reg_en, 0);
    t_req = 4'b0000;
    tick();
    for (int i = 0; i < NR; i++) chk("t5_bank", dut_bank[i], snap[i]);

    // 6: collision, last write wins
    do_reset();
    t_req = 4'b0011;
    t_addr[0] = 3'd2; t_data[0] = 32'd1;
    t_addr[1] = 3'd2; t_data[1] = 32'd2;
    tick();
    chk("t6_a", bif.ack, 4'b0001);
    t_req = 4'b0010;
    tick();
    chk("t6_b", bif.ack, 4'b0010);
    t_req = 4'b0000;
    tick();
    chk("t6_bank", dut_bank[2], 32'd2);

    // Random requesters obeying the hold-until-ack contract
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NQ; i++) begin
        if (exp_ack[i]) begin
          if ($urandom_range(1) == 1) begin
            t_addr[i] = AW'($urandom_range(7));
            t_data[i] = $urandom;
            t_req[i]  = 1'b1;
          end else begin
            t_req[i] = 1'b0;
          end
        end else if (!t_req[i] && $urandom_range(2) == 0) begin
          t_addr[i] = AW'($urandom_range(7));
          t_data[i] = $urandom;
          t_req[i]  = 1'b1;
        end
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
